// File: rtl/mtf_neuron_scheduler_pkg.sv
// Shared types and default constants for the MTF neuron scheduler.
// Sweep state encoding, config-select codes and datapath defaults.
package mtf_neuron_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_WRITE,
        ST_PUBLISH
    } state_e;

    localparam logic CFG_SEL_IEXT   = 1'b0;
    localparam logic CFG_SEL_THRESH = 1'b1;

    localparam int DEF_N_NEURONS  = 4;
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_TICK_DIV   = 1000;
    localparam int DEF_IEXT_GAIN  = 20;
    localparam int DEF_LEAK_SHIFT = 3;

endpackage

// File: rtl/mtf_neuron_scheduler_if.sv
// Host/gait-side bus of the MTF neuron scheduler: config writes, voltage monitor,
// tick enable and the spike-vector valid/ready handshake.
interface mtf_neuron_scheduler_if
    import mtf_neuron_scheduler_pkg::*;
#(
    parameter int N_NEURONS = DEF_N_NEURONS,
    parameter int WIDTH     = DEF_WIDTH
) ();
    localparam int AW = $clog2(N_NEURONS);

    logic                 enable;
    logic                 cfg_we;
    logic [AW-1:0]        cfg_addr;
    logic                 cfg_sel;
    logic [WIDTH-1:0]     cfg_wdata;
    logic [AW-1:0]        mon_addr;
    logic [WIDTH-1:0]     mon_voltage;
    logic [N_NEURONS-1:0] spike_vec;
    logic                 spike_valid;
    logic                 spike_ready;
    logic                 busy;
    logic                 overrun;

    modport master (
        output enable, cfg_we, cfg_addr, cfg_sel, cfg_wdata, mon_addr, spike_ready,
        input  mon_voltage, spike_vec, spike_valid, busy, overrun
    );

    modport slave (
        input  enable, cfg_we, cfg_addr, cfg_sel, cfg_wdata, mon_addr, spike_ready,
        output mon_voltage, spike_vec, spike_valid, busy, overrun
    );

endinterface

// File: rtl/mtf_neuron_scheduler_update_core.sv
// Combinational MTF membrane update for one neuron: spike/reset check, then
// leaky integration toward i_ext*IEXT_GAIN, saturated to [0, 2^WIDTH-1].
module mtf_update_core
    import mtf_neuron_scheduler_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int IEXT_GAIN  = DEF_IEXT_GAIN,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
    input  logic [WIDTH-1:0] v_i,
    input  logic [WIDTH-1:0] iext_i,
    input  logic [WIDTH-1:0] thresh_i,
    output logic [WIDTH-1:0] v_next_o,
    output logic             spike_o
);
    localparam int EW = 2 * WIDTH + 2;
    localparam logic signed [EW-1:0] GAIN = EW'(IEXT_GAIN);
    localparam logic signed [EW-1:0] VMAX = EW'((2 ** WIDTH) - 1);

    logic signed [EW-1:0] v_s;
    logic signed [EW-1:0] iext_s;
    logic signed [EW-1:0] drive;
    logic signed [EW-1:0] dv;
    logic signed [EW-1:0] sum;

    assign v_s    = $signed({{(EW - WIDTH){1'b0}}, v_i});
    assign iext_s = $signed({{(EW - WIDTH){1'b0}}, iext_i});

    always_comb begin
        drive    = iext_s * GAIN;
        dv       = (drive - v_s) >>> LEAK_SHIFT;
        sum      = v_s + dv;
        v_next_o = '0;
        spike_o  = 1'b0;
        // thresh of zero parks the neuron at 0; a spike resets before any integration
        if (thresh_i == '0) begin
            v_next_o = '0;
        end else if (v_i >= thresh_i) begin
            spike_o  = 1'b1;
            v_next_o = '0;
        end else if (sum[EW-1]) begin
            v_next_o = '0;
        end else if (sum > VMAX) begin
            v_next_o = '1;
        end else begin
            v_next_o = sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mtf_neuron_scheduler.sv
// Time-multiplexes one MTF update core across N_NEURONS neurons once per tick and
// publishes the resulting spike vector over a valid/ready handshake.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a tick; live cfg copied to shadow on tick
// ST_LOAD    | latch stored voltage and shadow cfg of neuron idx
// ST_COMPUTE | register core result and spike bit of neuron idx
// ST_WRITE   | write voltage back; advance idx or go to publish
// ST_PUBLISH | spike_vec valid, waiting for spike_ready
module mtf_neuron_scheduler
    import mtf_neuron_scheduler_pkg::*;
#(
    parameter int N_NEURONS  = DEF_N_NEURONS,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int IEXT_GAIN  = DEF_IEXT_GAIN,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    mtf_neuron_scheduler_if.slave  bus
);
    localparam int AW = $clog2(N_NEURONS);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [AW-1:0] LAST_IDX = AW'(N_NEURONS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    state_e               state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        cnt_q;
    logic                 tick_q;

    logic [WIDTH-1:0]     v_rf_q        [N_NEURONS];
    logic [WIDTH-1:0]     iext_live_q   [N_NEURONS];
    logic [WIDTH-1:0]     thresh_live_q [N_NEURONS];
    logic [WIDTH-1:0]     iext_shd_q    [N_NEURONS];
    logic [WIDTH-1:0]     thresh_shd_q  [N_NEURONS];

    logic [WIDTH-1:0]     v_op_q, iext_op_q, thresh_op_q, v_next_q;
    logic [N_NEURONS-1:0] spike_acc_q, spike_vec_q;
    logic                 overrun_q;

    logic [WIDTH-1:0]     core_v_next;
    logic                 core_spike;

    mtf_update_core #(
        .WIDTH      (WIDTH),
        .IEXT_GAIN  (IEXT_GAIN),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_core (
        .v_i      (v_op_q),
        .iext_i   (iext_op_q),
        .thresh_i (thresh_op_q),
        .v_next_o (core_v_next),
        .spike_o  (core_spike)
    );

    // tick is registered: it is seen by the FSM the cycle after the count wraps
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= bus.enable && (cnt_q == CNT_LAST);
            if (bus.enable) begin
                cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (tick_q) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end
            end
            ST_LOAD:    state_d = ST_COMPUTE;
            ST_COMPUTE: state_d = ST_WRITE;
            ST_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_PUBLISH;
                end else begin
                    state_d = ST_LOAD;
                    idx_d   = idx_q + AW'(1);
                end
            end
            ST_PUBLISH: begin
                if (bus.spike_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                v_rf_q[k]        <= '0;
                iext_live_q[k]   <= '0;
                thresh_live_q[k] <= '0;
                iext_shd_q[k]    <= '0;
                thresh_shd_q[k]  <= '0;
            end
            v_op_q      <= '0;
            iext_op_q   <= '0;
            thresh_op_q <= '0;
            v_next_q    <= '0;
            spike_acc_q <= '0;
            spike_vec_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            if (bus.cfg_we) begin
                if (bus.cfg_sel == CFG_SEL_THRESH) begin
                    thresh_live_q[bus.cfg_addr] <= bus.cfg_wdata;
                end else if (bus.cfg_sel == CFG_SEL_IEXT) begin
                    iext_live_q[bus.cfg_addr] <= bus.cfg_wdata;
                end
            end
            // shadow copy samples the live bank before a same-cycle host write lands
            if (state_q == ST_IDLE && tick_q) begin
                iext_shd_q   <= iext_live_q;
                thresh_shd_q <= thresh_live_q;
                spike_acc_q  <= '0;
            end
            if (tick_q && state_q != ST_IDLE) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_LOAD: begin
                    v_op_q      <= v_rf_q[idx_q];
                    iext_op_q   <= iext_shd_q[idx_q];
                    thresh_op_q <= thresh_shd_q[idx_q];
                end
                ST_COMPUTE: begin
                    v_next_q           <= core_v_next;
                    spike_acc_q[idx_q] <= core_spike;
                end
                ST_WRITE: begin
                    v_rf_q[idx_q] <= v_next_q;
                    if (idx_q == LAST_IDX) spike_vec_q <= spike_acc_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.spike_valid = (state_q == ST_PUBLISH);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.spike_vec   = spike_vec_q;
    assign bus.overrun     = overrun_q;
    assign bus.mon_voltage = v_rf_q[bus.mon_addr];

endmodule

// File: tb/tb_mtf_neuron_scheduler.sv
// Self-checking bench for mtf_neuron_scheduler: timestep-level reference model with
// per-cycle output compare, directed MTF scenarios and randomized traffic.
module tb_mtf_neuron_scheduler;
    import mtf_neuron_scheduler_pkg::*;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int TDIV  = 16;
    localparam int GAIN  = 20;
    localparam int SHIFT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mtf_neuron_scheduler_if #(.N_NEURONS(N), .WIDTH(W)) bus ();

    mtf_neuron_scheduler #(
        .N_NEURONS (N),
        .WIDTH     (W),
        .TICK_DIV  (TDIV),
        .IEXT_GAIN (GAIN),
        .LEAK_SHIFT(SHIFT)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int       m_cnt;
    bit       m_tick;
    int       m_el;          // cycles into current sweep; -1 when idle
    int       m_v     [N];
    int       m_new   [N];
    int       live_i  [N];
    int       live_t  [N];
    bit [N-1:0] m_spk, m_vec;
    bit       m_valid, m_ovr;

    function automatic int floor_div(int a, int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic int mtf_next(int v, int i, int t);
        int s;
        if (t == 0) return 0;
        if (v >= t) return 0;
        s = v + floor_div(i * GAIN - v, 2 ** SHIFT);
        if (s < 0) return 0;
        if (s > 2 ** W - 1) return 2 ** W - 1;
        return s;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_tick = 0; m_el = -1;
        m_spk = '0; m_vec = '0; m_valid = 0; m_ovr = 0;
        for (int k = 0; k < N; k++) begin
            m_v[k] = 0; m_new[k] = 0; live_i[k] = 0; live_t[k] = 0;
        end
    endtask

    task automatic model_step();
        if (m_el < 0) begin
            if (m_tick) begin
                for (int k = 0; k < N; k++) begin
                    m_spk[k] = (live_t[k] != 0) && (m_v[k] >= live_t[k]);
                    m_new[k] = mtf_next(m_v[k], live_i[k], live_t[k]);
                end
                m_el = 0;
            end
        end else begin
            if (m_tick) m_ovr = 1;
            if (m_el < 3 * N) begin
                // neuron k's voltage becomes visible after its third sweep cycle
                if (m_el % 3 == 2) m_v[m_el / 3] = m_new[m_el / 3];
                m_el++;
                if (m_el == 3 * N) begin
                    m_valid = 1;
                    m_vec   = m_spk;
                end
            end else if (bus.spike_ready) begin
                m_valid = 0;
                m_el    = -1;
            end
        end
        if (bus.cfg_we) begin
            if (bus.cfg_sel) live_t[bus.cfg_addr] = int'(bus.cfg_wdata);
            else             live_i[bus.cfg_addr] = int'(bus.cfg_wdata);
        end
        m_tick = bus.enable && (m_cnt == TDIV - 1);
        if (bus.enable) m_cnt = (m_cnt == TDIV - 1) ? 0 : m_cnt + 1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("busy",        bus.busy,        longint'(m_el >= 0));
                chk("spike_valid", bus.spike_valid, m_valid);
                chk("spike_vec",   bus.spike_vec,   m_vec);
                chk("overrun",     bus.overrun,     m_ovr);
                chk("mon_voltage", bus.mon_voltage, m_v[bus.mon_addr]);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wr(input int a, input int s, input int d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 2'(a);
        bus.cfg_sel   = 1'(s);
        bus.cfg_wdata = 8'(d);
        @(posedge clk); #1;
        bus.cfg_we    = 1'b0;
    endtask

    task automatic run_sweep(input int s, input int ev, input int a0, input int e0,
                             input int a1, input int e1, input bit wen,
                             input int wa, input int ws, input int wd);
        bit seen = 0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            seen = bus.spike_valid;
        end
        chk($sformatf("sweep%0d_valid_seen", s), seen, 1);
        chk($sformatf("sweep%0d_vec", s), bus.spike_vec, ev);
        @(posedge clk); #1;
        if (wen) begin
            bus.cfg_we = 1'b1; bus.cfg_addr = 2'(wa); bus.cfg_sel = 1'(ws); bus.cfg_wdata = 8'(wd);
        end
        bus.mon_addr = 2'(a0);
        @(negedge clk);
        chk($sformatf("sweep%0d_v%0d", s, a0), bus.mon_voltage, e0);
        @(posedge clk); #1;
        bus.cfg_we   = 1'b0;
        bus.mon_addr = 2'(a1);
        @(negedge clk);
        chk($sformatf("sweep%0d_v%0d", s, a1), bus.mon_voltage, e1);
    endtask

    // per-sweep expectations: vec, n0 voltage, (addr, voltage) of a second neuron
    int exp_vec [10] = '{0, 2, 0, 2, 0, 2, 0, 3, 0, 0};
    int exp_v0  [10] = '{2, 4, 6, 7, 8, 9, 10, 0, 2, 4};
    int exp_a1  [10] = '{3, 3, 3, 1, 1, 1, 1, 1, 1, 1};
    int exp_v1  [10] = '{25, 46, 40, 0, 255, 0, 255, 0, 255, 0};

    initial begin
        int  found;
        bit  hit;
        bus.enable = 0; bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_sel = 0;
        bus.cfg_wdata = '0; bus.mon_addr = '0; bus.spike_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_busy",    bus.busy,        0);
        chk("rst_valid",   bus.spike_valid, 0);
        chk("rst_vec",     bus.spike_vec,   0);
        chk("rst_overrun", bus.overrun,     0);
        chk("rst_mon",     bus.mon_voltage, 0);
        @(posedge clk); #1;

        wr(0, CFG_SEL_IEXT, 1);    wr(0, CFG_SEL_THRESH, 10);
        wr(1, CFG_SEL_IEXT, 255);  wr(1, CFG_SEL_THRESH, 200);
        wr(3, CFG_SEL_IEXT, 10);   wr(3, CFG_SEL_THRESH, 255);
        bus.enable = 1'b1;
        bus.spike_ready = 1'b1;

        for (int s = 1; s <= 10; s++) begin
            run_sweep(s, exp_vec[s-1], 0, exp_v0[s-1], exp_a1[s-1], exp_v1[s-1],
                      (s == 2) || (s == 10),
                      (s == 2) ? 3 : 0,
                      (s == 2) ? 0 : 1,
                      (s == 2) ? 0 : 4);
            if (s == 8) begin
                @(posedge clk); #1;
                hit = m_tick;
                for (int n = 0; n < 40 && !hit; n++) begin
                    @(posedge clk); #1;
                    hit = m_tick;
                end
                chk("tick_cycle_found", hit, 1);
                wr(1, CFG_SEL_THRESH, 0);
            end
        end

        // backpressure on sweep 11 (n0 spikes at thresh 4)
        @(posedge clk); #1;
        bus.spike_ready = 1'b0;
        hit = 0;
        for (int n = 0; n < 60 && !hit; n++) begin
            @(negedge clk);
            hit = bus.spike_valid;
        end
        chk("bp_valid_seen", hit, 1);
        repeat (40) @(negedge clk);
        chk("bp_valid_held", bus.spike_valid, 1);
        chk("bp_vec_held",   bus.spike_vec,   1);
        chk("bp_overrun",    bus.overrun,     1);
        chk("bp_busy",       bus.busy,        1);
        @(posedge clk); #1;
        bus.spike_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", bus.spike_valid, 0);
        chk("bp_release_busy",  bus.busy,        0);

        // randomized traffic
        @(posedge clk); #1;
        for (int c = 0; c < 1500; c++) begin
            bus.enable      = ($urandom_range(7) != 0);
            bus.spike_ready = ($urandom_range(1) != 0);
            bus.cfg_we      = ($urandom_range(2) == 0);
            bus.cfg_addr    = 2'($urandom_range(N - 1));
            bus.cfg_sel     = 1'($urandom_range(1));
            bus.cfg_wdata   = 8'($urandom_range(bus.cfg_sel ? 255 : 20));
            bus.mon_addr    = 2'($urandom_range(N - 1));
            @(posedge clk); #1;
        end
        bus.cfg_we = 1'b0; bus.enable = 1'b1; bus.spike_ready = 1'b1;
        bus.mon_addr = 2'd1;

        // async reset during COMPUTE of neuron 2
        hit = (m_el == 7);
        for (int n = 0; n < 300 && !hit; n++) begin
            @(posedge clk); #1;
            hit = (m_el == 7);
        end
        chk("compute2_found", hit, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",    bus.busy,        0);
        chk("arst_valid",   bus.spike_valid, 0);
        chk("arst_vec",     bus.spike_vec,   0);
        chk("arst_overrun", bus.overrun,     0);
        chk("arst_mon",     bus.mon_voltage, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        found = -1;
        for (int n = 0; n < 60 && found < 0; n++) begin
            @(negedge clk);
            if (bus.spike_valid) found = n;
        end
        chk("post_reset_latency", found, 29);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
